// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage. Issues load/store requests on a
//                ready/rvalid data bus, aligns load data and replicates store
//                data across byte lanes, stalls the pipe while an access is
//                outstanding and registers the writeback bundle.
//  Ports       :
//    clk, rst                 - clock, synchronous active-high reset
//    ex2mem_reg_wen/_waddr    - destination register write enable / address
//    ex2mem_alu_out           - writeback value for non-load instructions
//    ex2mem_mem_rd/_mem_wr    - load / store present
//    ex2mem_mem_rd_op         - load size [1:0], unsigned flag [2]
//    ex2mem_mem_wr_op         - store size
//    ex2mem_lsu_addr/_wdata   - effective address / store data
//    ex2mem_ill_instr         - illegal-instruction flag passed down the pipe
//    dbus_*                   - data bus request, address, data, byte enables
//    mem_stall                - freeze upstream stages and ex2mem registers
//    mem2wb_*                 - registered writeback bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex2mem_reg_wen,
  input  logic [4:0]      ex2mem_reg_waddr,
  input  logic [XLEN-1:0] ex2mem_alu_out,
  input  logic            ex2mem_mem_rd,
  input  logic            ex2mem_mem_wr,
  input  logic [2:0]      ex2mem_mem_rd_op,
  input  logic [1:0]      ex2mem_mem_wr_op,
  input  logic [XLEN-1:0] ex2mem_lsu_addr,
  input  logic [XLEN-1:0] ex2mem_lsu_wdata,
  input  logic            ex2mem_ill_instr,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_ready,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            mem_stall,
  output logic            mem2wb_reg_wen,
  output logic [4:0]      mem2wb_reg_waddr,
  output logic [XLEN-1:0] mem2wb_reg_wdata,
  output logic            mem2wb_ill_instr,
  output logic            mem2wb_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic            mem_op;
  logic            is_load;
  logic [1:0]      size;
  logic [1:0]      lane;
  logic            misaligned;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  // A load takes priority if both op flags are (illegally) set together.
  assign is_load    = ex2mem_mem_rd;
  assign mem_op     = ex2mem_mem_rd | ex2mem_mem_wr;
  assign size       = is_load ? ex2mem_mem_rd_op[1:0] : ex2mem_mem_wr_op;
  assign lane       = ex2mem_lsu_addr[1:0];
  assign misaligned = mem_op & (((size == 2'b01) & lane[0]) |
                                (size[1] & (lane != 2'b00)));

  // Bus address/data are driven straight from the ex2mem registers; those
  // are frozen by mem_stall, which keeps the request stable while in REQ.
  assign dbus_we   = ex2mem_mem_wr & ~ex2mem_mem_rd;
  assign dbus_addr = {ex2mem_lsu_addr[XLEN-1:2], 2'b00};

  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = ex2mem_lsu_wdata;
    case (size)
      2'b00: begin
        dbus_be    = 4'b0001 << lane;
        dbus_wdata = {(XLEN/8){ex2mem_lsu_wdata[7:0]}};
      end
      2'b01: begin
        dbus_be    = 4'b0011 << lane;
        dbus_wdata = {(XLEN/16){ex2mem_lsu_wdata[15:0]}};
      end
      default: begin
        dbus_be    = 4'b1111;
        dbus_wdata = ex2mem_lsu_wdata;
      end
    endcase
  end

  // Load lane extraction and zero/sign extension.
  assign ld_byte = dbus_rdata[{lane, 3'b000} +: 8];
  assign ld_half = dbus_rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = dbus_rdata;
    case (ex2mem_mem_rd_op[1:0])
      2'b00: load_data = ex2mem_mem_rd_op[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                             : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      2'b01: load_data = ex2mem_mem_rd_op[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                             : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: load_data = dbus_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state, bus request and stall
  always_comb begin
    state_next = state;
    dbus_req   = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        // Misaligned accesses never reach the bus and never stall.
        if (mem_op && !misaligned) begin
          dbus_req = 1'b1;
          if (!dbus_ready) begin
            state_next = REQ;
            mem_stall  = 1'b1;
          end else if (is_load) begin
            state_next = RESP;
            mem_stall  = 1'b1;
          end
        end
      end
      REQ: begin
        dbus_req  = 1'b1;
        mem_stall = 1'b1;
        if (dbus_ready) begin
          if (is_load) begin
            state_next = RESP;
          end else begin
            state_next = IDLE;
            mem_stall  = 1'b0;
          end
        end
      end
      RESP: begin
        // rvalid is only looked at here, so one arriving alongside ready
        // is never taken as this request's data.
        mem_stall = 1'b1;
        if (dbus_rvalid) begin
          state_next = IDLE;
          mem_stall  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      state_next = IDLE;
      dbus_req   = 1'b0;
      mem_stall  = 1'b0;
    end
  end

  // Writeback registers: capture on a non-stall cycle, bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem2wb_reg_wen    <= 1'b0;
      mem2wb_reg_waddr  <= 5'd0;
      mem2wb_reg_wdata  <= '0;
      mem2wb_ill_instr  <= 1'b0;
      mem2wb_misaligned <= 1'b0;
    end else if (mem_stall) begin
      mem2wb_reg_wen    <= 1'b0;
      mem2wb_ill_instr  <= 1'b0;
      mem2wb_misaligned <= 1'b0;
    end else begin
      mem2wb_reg_wen    <= ex2mem_reg_wen & ~misaligned;
      mem2wb_reg_waddr  <= ex2mem_reg_waddr;
      mem2wb_reg_wdata  <= is_load ? load_data : ex2mem_alu_out;
      mem2wb_ill_instr  <= ex2mem_ill_instr;
      mem2wb_misaligned <= misaligned;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Table of operations with
//                bus response timing and expected results; expected writeback
//                records go through a queue and are compared when the stage
//                completes. Hand-written sequences cover reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex2mem_reg_wen;
  logic [4:0]  ex2mem_reg_waddr;
  logic [31:0] ex2mem_alu_out;
  logic        ex2mem_mem_rd;
  logic        ex2mem_mem_wr;
  logic [2:0]  ex2mem_mem_rd_op;
  logic [1:0]  ex2mem_mem_wr_op;
  logic [31:0] ex2mem_lsu_addr;
  logic [31:0] ex2mem_lsu_wdata;
  logic        ex2mem_ill_instr;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ready;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic        mem2wb_reg_wen;
  logic [4:0]  mem2wb_reg_waddr;
  logic [31:0] mem2wb_reg_wdata;
  logic        mem2wb_ill_instr;
  logic        mem2wb_misaligned;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex2mem_reg_wen    (ex2mem_reg_wen),
    .ex2mem_reg_waddr  (ex2mem_reg_waddr),
    .ex2mem_alu_out    (ex2mem_alu_out),
    .ex2mem_mem_rd     (ex2mem_mem_rd),
    .ex2mem_mem_wr     (ex2mem_mem_wr),
    .ex2mem_mem_rd_op  (ex2mem_mem_rd_op),
    .ex2mem_mem_wr_op  (ex2mem_mem_wr_op),
    .ex2mem_lsu_addr   (ex2mem_lsu_addr),
    .ex2mem_lsu_wdata  (ex2mem_lsu_wdata),
    .ex2mem_ill_instr  (ex2mem_ill_instr),
    .dbus_req          (dbus_req),
    .dbus_we           (dbus_we),
    .dbus_addr         (dbus_addr),
    .dbus_wdata        (dbus_wdata),
    .dbus_be           (dbus_be),
    .dbus_ready        (dbus_ready),
    .dbus_rvalid       (dbus_rvalid),
    .dbus_rdata        (dbus_rdata),
    .mem_stall         (mem_stall),
    .mem2wb_reg_wen    (mem2wb_reg_wen),
    .mem2wb_reg_waddr  (mem2wb_reg_waddr),
    .mem2wb_reg_wdata  (mem2wb_reg_wdata),
    .mem2wb_ill_instr  (mem2wb_ill_instr),
    .mem2wb_misaligned (mem2wb_misaligned)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic        ill;
    int          rdy_wait;   // req cycles with ready low before acceptance
    int          rv_wait;    // cycles from acceptance to rvalid
    logic        rv_early;   // also pulse rvalid in the acceptance cycle
    int          e_req;
    int          e_stall;
    logic [31:0] e_baddr;
    logic [3:0]  e_be;
    logic [31:0] e_bwdata;
    logic        e_wen;
    logic [31:0] e_wb;
    logic        chk_wb;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wb;
    logic        ill;
    logic        mis;
    logic        chk_wb;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[14];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got=%h need=%h", name, got, need);
    end
  endtask

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [2:0] op, input logic [31:0] addr,
    input logic [31:0] sdata, input logic [31:0] alu, input logic [31:0] rdata,
    input logic wen, input logic [4:0] waddr, input logic ill,
    input int rdy_wait, input int rv_wait, input logic rv_early,
    input int e_req, input int e_stall, input logic [31:0] e_baddr, input logic [3:0] e_be,
    input logic [31:0] e_bwdata, input logic e_wen, input logic [31:0] e_wb,
    input logic chk_wb, input logic e_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.sdata = sdata; v.alu = alu;
    v.rdata = rdata; v.wen = wen; v.waddr = waddr; v.ill = ill;
    v.rdy_wait = rdy_wait; v.rv_wait = rv_wait; v.rv_early = rv_early;
    v.e_req = e_req; v.e_stall = e_stall; v.e_baddr = e_baddr; v.e_be = e_be;
    v.e_bwdata = e_bwdata; v.e_wen = e_wen; v.e_wb = e_wb; v.chk_wb = chk_wb; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic clear_inputs();
    ex2mem_reg_wen   = 1'b0;
    ex2mem_reg_waddr = 5'd0;
    ex2mem_alu_out   = 32'd0;
    ex2mem_mem_rd    = 1'b0;
    ex2mem_mem_wr    = 1'b0;
    ex2mem_mem_rd_op = 3'd0;
    ex2mem_mem_wr_op = 2'd0;
    ex2mem_lsu_addr  = 32'd0;
    ex2mem_lsu_wdata = 32'd0;
    ex2mem_ill_instr = 1'b0;
    dbus_ready       = 1'b0;
    dbus_rvalid      = 1'b0;
    dbus_rdata       = 32'd0;
  endtask

  task automatic pop_and_compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("wb",
            {mem2wb_reg_wen, mem2wb_reg_waddr, mem2wb_ill_instr, mem2wb_misaligned,
             e.chk_wb ? mem2wb_reg_wdata : 32'h0},
            {e.wen, e.waddr, e.ill, e.mis, e.chk_wb ? e.wb : 32'h0});
    end
  endtask

  // Drives one operation, acts as the bus slave and checks bus, stall and
  // writeback behaviour until the stage completes it.
  task automatic do_op(input vec_t v);
    exp_t e;
    int   req_seen = 0;
    int   stalls   = 0;
    int   acc_c    = 0;
    logic accepted = 1'b0;
    logic stalled;
    logic done     = 1'b0;
    @(negedge clk);
    ex2mem_mem_rd    = v.rd;
    ex2mem_mem_wr    = v.wr;
    ex2mem_mem_rd_op = v.op;
    ex2mem_mem_wr_op = v.op[1:0];
    ex2mem_lsu_addr  = v.addr;
    ex2mem_lsu_wdata = v.sdata;
    ex2mem_alu_out   = v.alu;
    ex2mem_reg_wen   = v.wen;
    ex2mem_reg_waddr = v.waddr;
    ex2mem_ill_instr = v.ill;
    dbus_rdata       = v.rdata;
    e.wen = v.e_wen; e.waddr = v.waddr; e.wb = v.e_wb; e.ill = v.ill;
    e.mis = v.e_mis; e.chk_wb = v.chk_wb;
    exp_q.push_back(e);
    for (int c = 0; c < 40; c++) begin
      dbus_ready  = !accepted && (req_seen == v.rdy_wait);
      dbus_rvalid = (accepted && (c - acc_c == v.rv_wait)) || (v.rv_early && dbus_ready);
      #1;
      if (dbus_req) begin
        check("bus",
              {dbus_addr, dbus_be, dbus_we, dbus_we ? dbus_wdata : 32'h0},
              {v.e_baddr, v.e_be, v.wr, v.wr ? v.e_bwdata : 32'h0});
        req_seen++;
        if (dbus_ready) begin
          accepted = 1'b1;
          acc_c    = c;
        end
      end
      stalled = mem_stall;
      if (stalled) stalls++;
      @(posedge clk);
      #1;
      if (!stalled) begin
        pop_and_compare();
        done = 1'b1;
        break;
      end
      check("bubble", {mem2wb_reg_wen, mem2wb_ill_instr, mem2wb_misaligned}, 3'b000);
      @(negedge clk);
    end
    if (!done) begin
      check("timeout", 1, 0);
      void'(exp_q.pop_front());
    end
    check("stall_cycles", stalls, v.e_stall);
    check("req_cycles", req_seen, v.e_req);
    dbus_ready  = 1'b0;
    dbus_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd wr op      addr   sdata         alu           rdata         wen wa ill rw rv er | req st baddr  be       bwdata        wen wb            chk mis
    vecs[0]  = mk(0, 0, 3'b000, 32'h0,   32'h0,        32'h55,       32'h0,        1, 5,  0, 0, 0, 0,  0, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h55,        1, 0);
    vecs[1]  = mk(1, 0, 3'b010, 32'h100, 32'h0,        32'h100,      32'hDEADBEEF, 1, 10, 0, 0, 2, 0,  1, 2, 32'h100, 4'b1111, 32'h0,        1, 32'hDEADBEEF,  1, 0);
    vecs[2]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h103,      32'h80FFFFFF, 1, 11, 0, 0, 1, 0,  1, 1, 32'h100, 4'b1000, 32'h0,        1, 32'hFFFFFF80,  1, 0);
    vecs[3]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h103,      32'h80FFFFFF, 1, 12, 0, 0, 2, 1,  1, 2, 32'h100, 4'b1000, 32'h0,        1, 32'h00000080,  1, 0);
    vecs[4]  = mk(0, 1, 3'b001, 32'h102, 32'h1234,     32'h102,      32'h0,        0, 0,  0, 3, 0, 0,  4, 3, 32'h100, 4'b1100, 32'h12341234, 0, 32'h102,       1, 0);
    vecs[5]  = mk(1, 0, 3'b010, 32'h101, 32'h0,        32'h101,      32'hDEADBEEF, 1, 13, 0, 0, 1, 0,  0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,         0, 1);
    vecs[6]  = mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h102,      32'h80010000, 1, 14, 0, 1, 1, 0,  2, 2, 32'h100, 4'b1100, 32'h0,        1, 32'hFFFF8001,  1, 0);
    vecs[7]  = mk(1, 0, 3'b101, 32'h200, 32'h0,        32'h200,      32'h1234F00D, 1, 15, 0, 0, 1, 0,  1, 1, 32'h200, 4'b0011, 32'h0,        1, 32'h0000F00D,  1, 0);
    vecs[8]  = mk(0, 1, 3'b000, 32'h101, 32'hFFFFFFAB, 32'h101,      32'h0,        0, 0,  0, 0, 0, 0,  1, 0, 32'h100, 4'b0010, 32'hABABABAB, 0, 32'h101,       1, 0);
    vecs[9]  = mk(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h104,      32'h0,        0, 0,  0, 2, 0, 0,  3, 2, 32'h104, 4'b1111, 32'hCAFEF00D, 0, 32'h104,       1, 0);
    vecs[10] = mk(0, 1, 3'b001, 32'h103, 32'h5678,     32'h103,      32'h0,        0, 0,  0, 0, 0, 0,  0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,         0, 1);
    vecs[11] = mk(0, 0, 3'b000, 32'h0,   32'h0,        32'hA5A5A5A5, 32'h0,        1, 31, 1, 0, 0, 0,  0, 0, 32'h0,   4'b0000, 32'h0,        1, 32'hA5A5A5A5,  1, 0);
    vecs[12] = mk(1, 0, 3'b000, 32'h100, 32'h0,        32'h100,      32'h1234567F, 1, 3,  1, 0, 1, 0,  1, 1, 32'h100, 4'b0001, 32'h0,        1, 32'h0000007F,  1, 0);
    vecs[13] = mk(1, 0, 3'b001, 32'h101, 32'h0,        32'h101,      32'hFFFFFFFF, 1, 6,  0, 0, 1, 0,  0, 0, 32'h0,   4'b0000, 32'h0,        0, 32'h0,         0, 1);

    // Reset with a load presented and the bus ready: nothing may go out.
    clear_inputs();
    rst              = 1'b1;
    ex2mem_mem_rd    = 1'b1;
    ex2mem_mem_rd_op = 3'b010;
    ex2mem_lsu_addr  = 32'h100;
    ex2mem_reg_wen   = 1'b1;
    ex2mem_reg_waddr = 5'd4;
    ex2mem_alu_out   = 32'h99;
    dbus_ready       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus", {dbus_req, mem_stall}, 2'b00);
    check("rst_wb", {mem2wb_reg_wen, mem2wb_ill_instr, mem2wb_misaligned,
                     mem2wb_reg_waddr, mem2wb_reg_wdata}, 40'h0);
    rst = 1'b0;
    clear_inputs();

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i]);
    end

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    ex2mem_mem_rd    = 1'b1;
    ex2mem_mem_rd_op = 3'b010;
    ex2mem_lsu_addr  = 32'h100;
    ex2mem_reg_wen   = 1'b1;
    ex2mem_reg_waddr = 5'd9;
    dbus_rdata       = 32'h12345678;
    dbus_ready       = 1'b1;
    #1;
    check("resp_issue", {dbus_req, mem_stall}, 2'b11);
    @(negedge clk);
    dbus_ready = 1'b0;
    #1;
    check("resp_wait", {dbus_req, mem_stall}, 2'b01);
    rst = 1'b1;
    #1;
    check("resp_rst_bus", {dbus_req, mem_stall}, 2'b00);
    @(posedge clk);
    #1;
    check("resp_rst_wb", {mem2wb_reg_wen, mem2wb_reg_waddr, mem2wb_reg_wdata}, 38'h0);
    @(negedge clk);
    rst              = 1'b0;
    clear_inputs();
    ex2mem_alu_out   = 32'h77;
    ex2mem_reg_waddr = 5'd2;
    dbus_rdata       = 32'h12345678;
    dbus_rvalid      = 1'b1;
    #1;
    check("late_rvalid_bus", {dbus_req, mem_stall}, 2'b00);
    @(posedge clk);
    #1;
    check("late_rvalid_wb", {mem2wb_reg_wen, mem2wb_reg_waddr, mem2wb_reg_wdata},
          {1'b0, 5'd2, 32'h77});
    dbus_rvalid = 1'b0;

    // The FSM must be back in IDLE: an immediate-ready store completes at once.
    do_op(vecs[8]);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
